ram_access_ctrl: RTL and testbench
==================================

Name: ram_access_ctrl

Overview:
- Two-requester controller for the shared single-port RAM: arbitrates, sequences each access and owns the RAM control lines and the write side of the tristate data bus.
- Port 0 is the CPU datapath; port 1 is the program loader/debug port.
- Each transaction is a fixed multi-cycle sequence ending in a one-cycle ack. Round-robin arbitration. Out-of-range addresses are rejected without touching the RAM.

Parameters:
- N, 68, highest valid RAM location; the RAM has N+1 words, 0..N.
- M, 8, data width.
- A, 7, address width.

Ports:
- clk1  in  1  single system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; hold until ack0.
- we0  in  1  port 0 direction: 1 = write, 0 = read.
- addr0  in  A  port 0 address.
- wdata0  in  M  port 0 write data.
- ack0  out  1  one-cycle completion pulse for port 0.
- req1, we1, addr1, wdata1, ack1: same as above, for port 1.
- rdata  out  M  read data; valid in the ack cycle and held until the next read completes.
- err  out  1  pulses with ack when the address exceeds N.
- busy  out  1  high in every state except IDLE.
- act_ram  out  1  RAM select.
- writeEn  out  1  RAM write strobe.
- address_r  out  A  RAM address.
- data  inout  M  RAM data bus; driven by this block only while writeEn=1, else high-Z.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; ack0=ack1=err=0; busy=0; act_ram=0; writeEn=0; address_r=0; rdata=0; data=Z.
  - Last-grant pointer resets to port 1, so port 0 wins the first tie.
  - Reset mid-transaction aborts it immediately: no ack, bus released at once.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any req is high, pick a winner and latch its we/addr/wdata plus the grant id; go to SETUP.
  - If exactly one req is high, it wins.
  - If both are high, the port not granted last wins (round-robin).
- SETUP:
  - If the latched addr > N: go to DONE with err flagged; act_ram stays 0.
  - Otherwise: act_ram=1, writeEn=0, address_r=latched addr; go to ACCESS.
- ACCESS:
  - act_ram=1.
  - Write: writeEn=1 and data=latched wdata for exactly this one cycle.
  - Read: writeEn=0, data=Z; rdata captures the data bus at the end of this cycle.
  - Go to DONE.
- DONE:
  - act_ram=0, writeEn=0, data=Z.
  - ack of the granted port=1 for this cycle only; err=1 if flagged.
  - address_r holds its value. Go to IDLE.
- Latency: a req sampled in IDLE at edge k gives ack high in the cycle after edge k+3. Minimum request-to-request spacing is 4 cycles.
- Requester obligations:
  - Request fields are latched at grant; later changes are ignored.
  - Dropping req after grant does not cancel the transaction; ack still pulses.
  - A req still high when the FSM returns to IDLE counts as a new request. The requester must drop req in the ack cycle if it wants no further access.
- Simultaneous events:
  - Both reqs rise in the same cycle: round-robin resolves it; the loser waits and is served next, with no starvation.
  - A new req arriving during SETUP/ACCESS/DONE is not sampled until IDLE.
- Bus safety: data is never driven while writeEn=0. Read-after-write turnaround is covered by DONE and IDLE.
- Address arithmetic: unsigned compare, latched addr > N. With A=7, addresses 69..127 are errors.
- err never asserts without ack.

Decomposition:
- Package ram_ctrl_pkg holds:
  - the state enum typedef (IDLE, SETUP, ACCESS, DONE);
  - port-id constants PORT_CPU=0 and PORT_LDR=1;
  - default N/M/A constants.
- Sub-module ram_rr_arb2: combinational 2-way round-robin pick plus the last-grant register. Inputs: req0, req1, a grant-enable strobe, clk1, rst_n. Outputs: grant id and a valid flag.

Test Plan:
- Write via port 0: req0=1, we0=1, addr0=5, wdata0=8'hA5 → writeEn=1 and data=A5 for exactly one cycle, ack0 pulses 4 edges after req. Then read addr 5 via port 1 → rdata=8'hA5 with ack1, err=0.
- Contention: req0 and req1 rise together, both writes (addr 10=8'h11, addr 11=8'h22) → port 0 acked first, port 1 acked 4 cycles later. Reading back both addresses gives 11 and 22.
- Fairness: both reqs held high for 16 cycles → acks alternate 0,1,0,1; no port gets two consecutive grants.
- Range: read at addr=68 → normal access, err=0. Read at addr=69 → act_ram stays 0, ack and err pulse together, 3 cycles after grant.
- Reset mid-op: assert rst_n=0 during ACCESS of a write → act_ram, writeEn and ack drop immediately and data goes to Z. After release, IDLE with busy=0, and the next req is served normally.
- Bus check: monitor the data bus throughout all tests → never driven by this block while writeEn=0. Also check req dropped during SETUP still yields its ack.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the two-port single-port-RAM access controller.
package ram_ctrl_pkg;

  localparam int unsigned N_DEF = 68;
  localparam int unsigned M_DEF = 8;
  localparam int unsigned A_DEF = 7;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

endpackage

// File: rtl/ram_rr_arb2.sv
// Two-way round-robin pick with a last-grant pointer; port 0 wins the first tie.
module ram_rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic clk1,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic grant_en,
  output logic gnt_id_c,
  output logic valid_c
);

  logic last_q;

  always_comb begin
    valid_c  = req0 | req1;
    gnt_id_c = PORT_CPU;
    if (req0 && req1) begin
      gnt_id_c = ~last_q;
    end else if (req1) begin
      gnt_id_c = PORT_LDR;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_LDR;
    end else if (grant_en) begin
      last_q <= gnt_id_c;
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Arbitrates two requesters onto a shared single-port RAM and sequences
// each access as grant -> setup -> access -> ack, owning the bus write side.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned M = M_DEF,
  parameter int unsigned A = A_DEF
) (
  input  logic         clk1,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         we0,
  input  logic [A-1:0] addr0,
  input  logic [M-1:0] wdata0,
  output logic         ack0,
  input  logic         req1,
  input  logic         we1,
  input  logic [A-1:0] addr1,
  input  logic [M-1:0] wdata1,
  output logic         ack1,
  output logic [M-1:0] rdata,
  output logic         err,
  output logic         busy,
  output logic         act_ram,
  output logic         writeEn,
  output logic [A-1:0] address_r,
  inout  wire  [M-1:0] data
);

  localparam logic [A:0] ADDR_MAX = (A+1)'(N);

  state_t       state_q, state_d;
  logic         id_q, id_d;
  logic         we_q, we_d;
  logic [A-1:0] addr_q, addr_d;
  logic [M-1:0] wdata_q, wdata_d;
  logic         flag_q, flag_d;

  logic         ack0_d, ack1_d, err_d, busy_d, act_d, wen_d;
  logic [A-1:0] address_d;
  logic [M-1:0] rdata_d;
  logic         grant_en_c, gnt_id_c, valid_c;

  ram_rr_arb2 u_arb (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .grant_en (grant_en_c),
    .gnt_id_c (gnt_id_c),
    .valid_c  (valid_c)
  );

  // Drive the bus only during the single write-strobe cycle.
  assign data = writeEn ? wdata_q : {M{1'bz}};

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    flag_d     = flag_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err_d      = 1'b0;
    act_d      = 1'b0;
    wen_d      = 1'b0;
    address_d  = address_r;
    rdata_d    = rdata;
    grant_en_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_c) begin
          grant_en_c = 1'b1;
          id_d       = gnt_id_c;
          we_d       = (gnt_id_c == PORT_LDR) ? we1    : we0;
          addr_d     = (gnt_id_c == PORT_LDR) ? addr1  : addr0;
          wdata_d    = (gnt_id_c == PORT_LDR) ? wdata1 : wdata0;
          flag_d     = 1'b0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        // Out-of-range requests skip the RAM entirely and just report err.
        if ({1'b0, addr_q} > ADDR_MAX) begin
          flag_d  = 1'b1;
          state_d = DONE;
        end else begin
          act_d     = 1'b1;
          address_d = addr_q;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        act_d = 1'b1;
        wen_d = we_q;
        if (!we_q) begin
          rdata_d = data;
        end
        state_d = DONE;
      end
      DONE: begin
        ack0_d  = (id_q == PORT_CPU);
        ack1_d  = (id_q == PORT_LDR);
        err_d   = flag_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      id_q      <= PORT_CPU;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      flag_q    <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      act_ram   <= 1'b0;
      writeEn   <= 1'b0;
      address_r <= '0;
      rdata     <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      flag_q    <= flag_d;
      ack0      <= ack0_d;
      ack1      <= ack1_d;
      err       <= err_d;
      busy      <= busy_d;
      act_ram   <= act_d;
      writeEn   <= wen_d;
      address_r <= address_d;
      rdata     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural RAM on the shared bus.
module tb_ram_access_ctrl;

  localparam int unsigned NN = 68;
  localparam int unsigned MM = 8;
  localparam int unsigned AA = 7;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AA-1:0] addr0 = '0, addr1 = '0;
  logic [MM-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err, busy, act_ram, writeEn;
  logic [MM-1:0] rdata;
  logic [AA-1:0] address_r;
  wire  [MM-1:0] data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk1 = ~clk1;

  ram_access_ctrl #(.N(NN), .M(MM), .A(AA)) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .ack0      (ack0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack1      (ack1),
    .rdata     (rdata),
    .err       (err),
    .busy      (busy),
    .act_ram   (act_ram),
    .writeEn   (writeEn),
    .address_r (address_r),
    .data      (data)
  );

  // RAM model: answers reads while selected, otherwise parks the bus at zero.
  logic [MM-1:0] mem [0:NN];
  logic [MM-1:0] ram_rd, bus_val;

  always_comb begin
    ram_rd = '0;
    if (int'(address_r) <= int'(NN)) ram_rd = mem[int'(address_r)];
    bus_val = act_ram ? ram_rd : '0;
  end

  assign data = writeEn ? {MM{1'bz}} : bus_val;

  always @(posedge clk1) begin
    if (act_ram && writeEn && int'(address_r) <= int'(NN)) mem[int'(address_r)] <= data;
  end

  always @(negedge clk1) begin
    if (!writeEn) begin
      n_tests++;
      if (data !== bus_val) begin
        n_fail++;
        $display("FAIL bus_driven_without_wen: data=%0h required=%0h", data, bus_val);
      end
    end
    if (err && !(ack0 || ack1)) begin
      n_tests++;
      n_fail++;
      $display("FAIL err_without_ack: err=%0b ack0=%0b ack1=%0b", err, ack0, ack1);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // One single-requester transaction; fields are scrambled after grant to
  // show they were latched.
  task automatic run_xact(input logic p, input logic we, input logic [AA-1:0] a,
                          input logic [MM-1:0] wd, output int lat, output logic [MM-1:0] rd,
                          output logic e, output int wen_cyc, output logic act_seen,
                          output int bad);
    lat = 0; rd = '0; e = 1'b0; wen_cyc = 0; act_seen = 1'b0; bad = 0;
    @(posedge clk1); #1;
    if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
    else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk1);
      if (i == 2) begin
        addr0 = ~a; addr1 = ~a; wdata0 = ~wd; wdata1 = ~wd; we0 = ~we; we1 = ~we;
      end
      if (act_ram) act_seen = 1'b1;
      if (writeEn) begin
        wen_cyc++;
        if (data !== wd || address_r !== a) bad++;
      end
      if (p ? ack0 : ack1) bad++;
      if (p ? ack1 : ack0) begin
        lat = i; rd = rdata; e = err;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  typedef struct {
    logic          p;
    logic          we;
    logic [AA-1:0] a;
    logic [MM-1:0] wd;
    logic [MM-1:0] exp_rd;
    logic          exp_err;
    int            exp_lat;
    int            exp_wen;
    logic          exp_act;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, wen_cyc, bad, t0, t1, nack;
    logic [MM-1:0] rd;
    logic e, act_seen;
    logic ids [8];
    logic [MM-1:0] rds [8];

    for (int i = 0; i <= int'(NN); i++) mem[i] = '0;

    vecs[0] = '{1'b0, 1'b1, 7'd5,   8'hA5, 8'h00, 1'b0, 5, 1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 7'd5,   8'h00, 8'hA5, 1'b0, 5, 0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 7'd68,  8'h3C, 8'hA5, 1'b0, 5, 1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 7'd68,  8'h00, 8'h3C, 1'b0, 5, 0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 7'd69,  8'h00, 8'h3C, 1'b1, 4, 0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 7'd127, 8'hFF, 8'h3C, 1'b1, 4, 0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 7'd5,   8'h00, 8'hA5, 1'b0, 5, 0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 7'd0,   8'h5A, 8'hA5, 1'b0, 5, 1, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 7'd0,   8'h00, 8'h5A, 1'b0, 5, 0, 1'b1};

    // Reset state
    @(negedge clk1);
    @(negedge clk1);
    chk("rst_ack0", 32'(ack0), 0);
    chk("rst_ack1", 32'(ack1), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_act_ram", 32'(act_ram), 0);
    chk("rst_writeEn", 32'(writeEn), 0);
    chk("rst_address_r", 32'(address_r), 0);
    chk("rst_rdata", 32'(rdata), 0);
    @(posedge clk1); #1;
    rst_n = 1'b1;

    // Table-driven single transactions
    foreach (vecs[k]) begin
      run_xact(vecs[k].p, vecs[k].we, vecs[k].a, vecs[k].wd, lat, rd, e, wen_cyc, act_seen, bad);
      chk($sformatf("v%0d_latency", k), 32'(lat), 32'(vecs[k].exp_lat));
      chk($sformatf("v%0d_rdata", k), 32'(rd), 32'(vecs[k].exp_rd));
      chk($sformatf("v%0d_err", k), 32'(e), 32'(vecs[k].exp_err));
      chk($sformatf("v%0d_wen_cycles", k), 32'(wen_cyc), 32'(vecs[k].exp_wen));
      chk($sformatf("v%0d_act_ram", k), 32'(act_seen), 32'(vecs[k].exp_act));
      chk($sformatf("v%0d_protocol", k), 32'(bad), 0);
    end

    // Contention: both rise together, port 0 first after a port-1 grant
    @(posedge clk1); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'd10; wdata0 = 8'h11;
    req1 = 1'b1; we1 = 1'b1; addr1 = 7'd11; wdata1 = 8'h22;
    t0 = 0; t1 = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk1);
      if (ack0) begin t0 = i; req0 = 1'b0; end
      if (ack1) begin t1 = i; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_ack0_cycle", 32'(t0), 5);
    chk("cont_ack1_cycle", 32'(t1), 9);

    run_xact(1'b0, 1'b0, 7'd10, 8'h00, lat, rd, e, wen_cyc, act_seen, bad);
    chk("cont_readback10", 32'(rd), 32'h11);
    run_xact(1'b1, 1'b0, 7'd11, 8'h00, lat, rd, e, wen_cyc, act_seen, bad);
    chk("cont_readback11", 32'(rd), 32'h22);

    // Fairness: both held, acks alternate starting with port 0
    @(posedge clk1); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'd10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 7'd11;
    nack = 0;
    for (int i = 1; i <= 26; i++) begin
      @(negedge clk1);
      if (ack0 || ack1) begin
        if (nack < 8) begin ids[nack] = ack1; rds[nack] = rdata; end
        nack++;
      end
      if (i == 18) begin req0 = 1'b0; req1 = 1'b0; end
    end
    chk("fair_ack_count", 32'(nack), 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("fair_id%0d", k), 32'(ids[k]), 32'(k % 2));
      chk($sformatf("fair_rdata%0d", k), 32'(rds[k]), (k % 2 == 1) ? 32'h22 : 32'h11);
    end

    // Req dropped during SETUP still completes
    @(posedge clk1); #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 7'd5;
    t1 = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk1);
      if (i == 2) begin
        chk("drop_busy_in_setup", 32'(busy), 1);
        req1 = 1'b0;
      end
      if (ack1 && t1 == 0) begin t1 = i; rd = rdata; end
    end
    chk("drop_ack1_cycle", 32'(t1), 5);
    chk("drop_rdata", 32'(rd), 32'hA5);

    // Reset during the write strobe aborts the write
    @(posedge clk1); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'd20; wdata0 = 8'h77;
    for (int i = 1; i <= 4; i++) @(negedge clk1);
    chk("rst_mid_wen_before", 32'(writeEn), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_act_ram", 32'(act_ram), 0);
    chk("rst_mid_writeEn", 32'(writeEn), 0);
    chk("rst_mid_ack0", 32'(ack0), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_bus_released", 32'(data), 0);
    req0 = 1'b0;
    @(posedge clk1);
    @(posedge clk1); #1;
    rst_n = 1'b1;
    @(negedge clk1);
    chk("rst_mid_idle_busy", 32'(busy), 0);
    chk("rst_mid_rdata", 32'(rdata), 0);
    chk("rst_mid_no_write", 32'(mem[20]), 0);

    run_xact(1'b0, 1'b0, 7'd5, 8'h00, lat, rd, e, wen_cyc, act_seen, bad);
    chk("post_rst_latency", 32'(lat), 5);
    chk("post_rst_rdata", 32'(rd), 32'hA5);
    chk("post_rst_err", 32'(e), 0);

    repeat (3) @(negedge clk1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
